// File: rtl/pc_pkg.sv
// Shared constants for the program-counter block: default widths, reset vector and ALU op codes.
package pc_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned PC_INC_STEP = 2;
    localparam logic [15:0] PC_RESET    = 16'h0000;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational add/subtract unit producing the PC-relative target and a zero flag.
module alu
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             aluop,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Results wrap modulo 2^WIDTH; no carry or overflow is reported.
    always_comb begin
        result = a + b;
        if (aluop == ALU_SUB) begin
            result = a - b;
        end
        zero = (result == '0);
    end

endmodule

// File: rtl/program_counter.sv
// PC register with fixed-step increment or ALU-computed jump target.
// Optional PC_STALL_EN adds a stall input that holds the PC (priority: reset > stall > jump).
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH    = PC_WIDTH,
    parameter int unsigned     INC_STEP = PC_INC_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = PC_RESET[WIDTH-1:0]
) (
    input  logic             clock,
    input  logic             reset,
`ifdef PC_STALL_EN
    input  logic             stall,
`endif
    input  logic [WIDTH-1:0] srcb,
    input  logic             aluop,
    input  logic             jump_en,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (pc_q),
        .b      (srcb),
        .aluop  (aluop),
        .result (alu_out),
        .zero   (zero)
    );

    always_comb begin
        pc_d = pc_q + STEP;
        if (jump_en) begin
            pc_d = alu_out;
        end
`ifdef PC_STALL_EN
        if (stall) begin
            pc_d = pc_q;
        end
`endif
    end

    // Reset takes priority so X on the other inputs cannot reach the register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter; covers the stall feature when PC_STALL_EN is defined.
module tb_program_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] srcb;
    logic        aluop;
    logic        jump_en;
    logic [15:0] pc;
    logic [15:0] alu_out;
    logic        zero;
`ifdef PC_STALL_EN
    logic        stall;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    program_counter dut (
        .clock   (clock),
        .reset   (reset),
`ifdef PC_STALL_EN
        .stall   (stall),
`endif
        .srcb    (srcb),
        .aluop   (aluop),
        .jump_en (jump_en),
        .pc      (pc),
        .alu_out (alu_out),
        .zero    (zero)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; srcb = 16'd2; aluop = 1'b0; jump_en = 1'b0;
`ifdef PC_STALL_EN
        stall = 1'b0;
`endif
        // Reset state and combinational ALU on the reset PC
        tick();
        check("reset_pc", pc, 16'h0000);
        check("reset_alu", alu_out, 16'h0002);
        check("reset_zero", {15'd0, zero}, 16'd0);

        reset = 1'b0;
        tick(); check("inc_1", pc, 16'h0002);
        tick(); check("inc_2", pc, 16'h0004);
        tick(); check("inc_3", pc, 16'h0006);

        // Jump add from pc=4
        reset = 1'b1; tick(); check("rst_again", pc, 16'h0000);
        reset = 1'b0; tick(); tick();
        check("pre_jump_pc", pc, 16'h0004);
        srcb = 16'h0010; aluop = 1'b0; jump_en = 1'b1;
        settle(); check("jump_add_alu", alu_out, 16'h0014);
        tick(); check("jump_add_pc", pc, 16'h0014);
        jump_en = 1'b0;
        tick(); check("after_jump_inc", pc, 16'h0016);

        // Subtract down to 8, then zero flag
        srcb = 16'h000E; aluop = 1'b1; jump_en = 1'b1;
        tick(); check("jump_sub_pc", pc, 16'h0008);
        jump_en = 1'b0; srcb = 16'h0008; aluop = 1'b1;
        settle();
        check("sub_zero_alu", alu_out, 16'h0000);
        check("sub_zero_flag", {15'd0, zero}, 16'd1);
        jump_en = 1'b1;
        tick(); check("sub_zero_pc", pc, 16'h0000);
        check("sub_wrap_alu", alu_out, 16'hFFF8);
        check("sub_wrap_zero", {15'd0, zero}, 16'd0);

        // Wrap-around in both directions
        srcb = 16'h0002; aluop = 1'b1; jump_en = 1'b1;
        tick(); check("jump_to_fffe", pc, 16'hFFFE);
        jump_en = 1'b0;
        tick(); check("inc_wrap", pc, 16'h0000);
        tick(); check("inc_after_wrap", pc, 16'h0002);
        srcb = 16'h0004; aluop = 1'b1; jump_en = 1'b1;
        settle(); check("neg_target_alu", alu_out, 16'hFFFE);
        tick(); check("neg_target_pc", pc, 16'hFFFE);

        // Operands without jump_en only move alu_out
        srcb = 16'h1234; aluop = 1'b0; jump_en = 1'b0;
        tick(); check("nojump_pc", pc, 16'h0000);
        check("nojump_alu", alu_out, 16'h1234);
        tick(); check("nojump_inc", pc, 16'h0002);

        // Reset beats a simultaneous jump, and tolerates X inputs
        reset = 1'b1; jump_en = 1'b1; srcb = 16'h0100; aluop = 1'b0;
        tick(); check("reset_vs_jump", pc, 16'h0000);
        srcb = 'x; aluop = 1'bx; jump_en = 1'bx;
        tick(); check("reset_x_inputs", pc, 16'h0000);
        reset = 1'b0; srcb = 16'h0000; aluop = 1'b0; jump_en = 1'b0;
        tick(); check("resume_inc", pc, 16'h0002);

`ifdef PC_STALL_EN
        tick(); tick();
        check("pre_stall_pc", pc, 16'h0006);
        stall = 1'b1; jump_en = 1'b1; srcb = 16'h0010; aluop = 1'b0;
        tick(); check("stall_hold", pc, 16'h0006);
        check("stall_alu_live", alu_out, 16'h0016);
        stall = 1'b0;
        tick(); check("stall_release_jump", pc, 16'h0016);
        jump_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Program-counter block for the 16-bit RISC core: a 16-bit PC register paired with a combinational add/subtract ALU whose A operand is the current PC. Each cycle the PC either advances by a fixed step or loads the ALU result (PC-relative jump/branch target). The block sits at the front of the fetch path and feeds the instruction-memory address.

## Interface
- `WIDTH`, 16, datapath and PC width in bits
- `INC_STEP`, 2, sequential increment added to the PC when no jump is taken
- `RESET_PC`, 16'h0000, PC value loaded on reset

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `srcb`  in  WIDTH  ALU B operand (jump offset)
- `aluop`  in  1  0 = add (pc + srcb), 1 = subtract (pc − srcb)
- `jump_en`  in  1  1 = load ALU result into PC on next edge
- `pc`  out  WIDTH  current PC (register output)
- `alu_out`  out  WIDTH  combinational ALU result
- `zero`  out  1  combinational, 1 when `alu_out` == 0

## Operation
- ALU: A operand is `pc` internally; `alu_out` = (pc + srcb) mod 2^WIDTH when `aluop`=0, (pc − srcb) mod 2^WIDTH when `aluop`=1. No carry/overflow outputs; results wrap.
- `zero` derived from `alu_out` only, same cycle.
- PC next-state priority at each rising edge: `reset` → RESET_PC; else `jump_en`=1 → `alu_out`; else `pc` + INC_STEP (mod 2^WIDTH).
- `srcb`/`aluop` with `jump_en`=0 affect only `alu_out`/`zero`, never `pc`.
- Inputs X/undriven while `reset`=1 must not corrupt `pc` (reset wins unconditionally).

## Timing
- Reset: `pc` = 16'h0000 on the first rising edge with `reset`=1; held while `reset` stays high. `alu_out`/`zero` then follow combinationally (e.g. srcb=2, add → alu_out=2, zero=0).
- Latency: `pc` updates 1 cycle after `jump_en`/operands are sampled; `alu_out`/`zero` 0-cycle combinational from `pc`, `srcb`, `aluop`.
- No combinational path from `jump_en` to any output.
- Wrap-around: pc=16'hFFFE, no jump → 16'h0000 next edge; jump with pc=16'h0004, srcb=6, sub → 16'hFFFE.
- Reset asserted mid-sequence (any `jump_en`): PC → RESET_PC on that edge; increment resumes the edge after deassertion.

## Configuration
- Macro `PC_STALL_EN`: when defined, adds input `stall` (1 bit). Priority becomes reset > stall > jump_en > increment; `stall`=1 holds `pc` unchanged (jump request ignored that cycle). `alu_out`/`zero` stay live during stall.
- Undefined: no `stall` port; PC changes every non-reset cycle.

## Structure
- Shared package `pc_pkg`: WIDTH default, INC_STEP default, RESET_PC, `aluop` encoding constants ALU_ADD=1'b0, ALU_SUB=1'b1.
- One sub-module: `alu` (operands A/B, `aluop`, result, zero), purely combinational; top instantiates it with A = `pc` and holds the PC register and next-PC mux.

## Test plan
- Reset: reset=1 for one edge, srcb=2, aluop=0, jump_en=0 → pc=0, alu_out=2, zero=0; after deassert pc = 2, 4, 6 on successive edges.
- Jump add: pc=4, srcb=16'h0010, aluop=0, jump_en=1 for one edge → pc=16'h0014, then 16'h0016.
- Subtract/zero: pc=8, srcb=8, aluop=1 → alu_out=0, zero=1 same cycle; jump_en=1 → pc=0.
- Wrap: pc=16'hFFFE, jump_en=0 → pc=0; pc=2, srcb=4, sub, jump → pc=16'hFFFE.
- Reset mid-run: reset=1 together with jump_en=1 → pc=0 (reset wins).
- With PC_STALL_EN: stall=1 with jump_en=1 at pc=6 → pc stays 6; stall=0 → jump taken next edge.
